// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 raster constants and colour type for the memory scan-out
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int CELL_W   = 40;
    localparam int CELL_H   = 30;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam int CNT_W    = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_mem_reader_if.sv
// rtl/vga_mem_reader_if.sv - memory read port plus VGA pins of the scan-out engine
interface vga_mem_reader_if;

    logic [7:0]  addressForVga;
    logic [31:0] rdataForVga;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_clk_en;
    logic        frame_start;

    modport master (
        output addressForVga,
        input  rdataForVga,
        output vga_hsync,
        output vga_vsync,
        output vga_blank_n,
        output vga_r,
        output vga_g,
        output vga_b,
        output vga_clk_en,
        output frame_start
    );

    modport slave (
        input  addressForVga,
        output rdataForVga,
        input  vga_hsync,
        input  vga_vsync,
        input  vga_blank_n,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  vga_clk_en,
        input  frame_start
    );

endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel tick, h/v raster counters, cell counters and sync/blank registers
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int CELL_W   = vga_pkg::CELL_W,
    parameter int CELL_H   = vga_pkg::CELL_H
) (
    input  logic             clk,
    input  logic             reset,
    output logic             tick,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic [3:0]       row,
    output logic [3:0]       col,
    output logic             active,
    output logic             hsync,
    output logic             vsync,
    output logic             blank_n
);

    localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HSS = H_ACTIVE + H_FP;
    localparam int HSE = HSS + H_SYNC - 1;
    localparam int VSS = V_ACTIVE + V_FP;
    localparam int VSE = VSS + V_SYNC - 1;

    logic             phase;
    logic [CNT_W-1:0] hx;
    logic [CNT_W-1:0] vy;

    assign tick   = phase;
    assign active = (h < CNT_W'(H_ACTIVE)) && (v < CNT_W'(V_ACTIVE));

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase   <= 1'b0;
            h       <= '0;
            v       <= '0;
            hx      <= '0;
            vy      <= '0;
            col     <= '0;
            row     <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            blank_n <= 1'b0;
        end else begin
            phase <= !phase;
            if (phase) begin
                // Registered from the pre-increment counters: outputs trail the raster by one pixel.
                hsync   <= !((h >= CNT_W'(HSS)) && (h <= CNT_W'(HSE)));
                vsync   <= !((v >= CNT_W'(VSS)) && (v <= CNT_W'(VSE)));
                blank_n <= active;
                if (h == CNT_W'(HT - 1)) begin
                    h   <= '0;
                    hx  <= '0;
                    col <= '0;
                    if (v == CNT_W'(VT - 1)) begin
                        v   <= '0;
                        vy  <= '0;
                        row <= '0;
                    end else begin
                        v <= v + CNT_W'(1);
                        if (v < CNT_W'(V_ACTIVE - 1)) begin
                            if (vy == CNT_W'(CELL_H - 1)) begin
                                vy  <= '0;
                                row <= row + 4'd1;
                            end else begin
                                vy <= vy + CNT_W'(1);
                            end
                        end else begin
                            vy  <= '0;
                            row <= '0;
                        end
                    end
                end else begin
                    h <= h + CNT_W'(1);
                    if (h < CNT_W'(H_ACTIVE - 1)) begin
                        if (hx == CNT_W'(CELL_W - 1)) begin
                            hx  <= '0;
                            col <= col + 4'd1;
                        end else begin
                            hx <= hx + CNT_W'(1);
                        end
                    end else begin
                        hx  <= '0;
                        col <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/vga_mem_reader.sv
// rtl/vga_mem_reader.sv - scans the first 256 data words out as a 16x16 grid of colour cells
module vga_mem_reader
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int CELL_W   = vga_pkg::CELL_W,
    parameter int CELL_H   = vga_pkg::CELL_H
) (
    input  logic              clk,
    input  logic              reset,
    vga_mem_reader_if.master  bus
);

    logic             tick;
    logic             active;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic [3:0]       row;
    logic [3:0]       col;
    logic             hsync;
    logic             vsync;
    logic             blank_n;
    logic             frame_start;
    rgb_t             rgb;
    logic [7:0]       unused_alpha;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CELL_W   (CELL_W),
        .CELL_H   (CELL_H)
    ) u_timing (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .h       (h),
        .v       (v),
        .row     (row),
        .col     (col),
        .active  (active),
        .hsync   (hsync),
        .vsync   (vsync),
        .blank_n (blank_n)
    );

    // Row already holds its value through horizontal blanking, so gate on the raster area.
    assign bus.addressForVga = active ? {row, col} : 8'h00;
    assign unused_alpha      = bus.rdataForVga[31:24];

    // Address moved on the previous tick; the 1-clk read has settled by this tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && (h == '0) && (v == '0);
            if (tick) begin
                rgb <= active ? rgb_t'(bus.rdataForVga[23:0]) : rgb_t'(24'h0);
            end
        end
    end

    assign bus.vga_hsync   = hsync;
    assign bus.vga_vsync   = vsync;
    assign bus.vga_blank_n = blank_n;
    assign bus.vga_r       = rgb.r;
    assign bus.vga_g       = rgb.g;
    assign bus.vga_b       = rgb.b;
    assign bus.vga_clk_en  = tick;
    assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_vga_mem_reader.sv
// tb/tb_vga_mem_reader.sv - self-checking bench for vga_mem_reader on a scaled-down raster
module tb_vga_mem_reader;

    localparam int HA = 64, HFP = 2, HS = 6, HBP = 4;
    localparam int VA = 48, VFP = 2, VS = 2, VBP = 3;
    localparam int CW = 4, CH = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int LINE_CLK  = 2 * HT;
    localparam int FRAME_CLK = 2 * HT * VT;
    localparam logic [26:0] RST_VEC = {1'b1, 1'b1, 1'b0, 24'h0};

    logic clk = 1'b0;
    logic reset = 1'b0;

    vga_mem_reader_if bus ();

    vga_mem_reader #(
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HS),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP),
        .CELL_W   (CW),
        .CELL_H   (CH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.rdataForVga <= (bus.addressForVga == 8'h11) ? 32'hAA00FF80 : 32'h0;
    end

    int n_checks = 0;
    int n_err = 0;

    logic [26:0] sb[$];
    logic [26:0] cur_exp;
    logic [26:0] popped;
    bit  mphase;
    bit  exp_fs;
    int  mx, my, cyc;
    bit  p_hs, p_vs, p_bl;
    int  hs_lo, vs_lo, bl_hi, lines;
    int  last_hs_fall, last_fs, n_fs;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d x=%0d y=%0d got=%h want=%h", tag, cyc, mx, my, act, exp);
        end
    endtask

    function automatic logic [7:0] model_addr(input int x, input int y);
        if (x < HA && y < VA) return {4'(y / CH), 4'(x / CW)};
        return 8'h00;
    endfunction

    function automatic logic [26:0] model_pix(input int x, input int y);
        logic bl, hs, vs;
        logic [23:0] rgb;
        bl  = (x < HA) && (y < VA);
        hs  = !((x >= HA + HFP) && (x < HA + HFP + HS));
        vs  = !((y >= VA + VFP) && (y < VA + VFP + VS));
        rgb = (bl && model_addr(x, y) == 8'h11) ? 24'h00FF80 : 24'h0;
        return {hs, vs, bl, rgb};
    endfunction

    function automatic logic [26:0] dut_pix();
        return {bus.vga_hsync, bus.vga_vsync, bus.vga_blank_n, bus.vga_r, bus.vga_g, bus.vga_b};
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_pix"}, 32'(dut_pix()), 32'(RST_VEC));
        check({tag, "_addr"}, 32'(bus.addressForVga), 32'h0);
        check({tag, "_fs"}, 32'(bus.frame_start), 32'h0);
        check({tag, "_clken"}, 32'(bus.vga_clk_en), 32'h0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        mphase = 1'b0;
        mx = 0;
        my = 0;
        cyc = 0;
        cur_exp = RST_VEC;
        sb.delete();
        p_hs = 1'b1;
        p_vs = 1'b1;
        p_bl = 1'b0;
        hs_lo = 0;
        vs_lo = 0;
        bl_hi = 0;
        lines = 0;
        last_hs_fall = -1;
        last_fs = -1;
    endtask

    task automatic step();
        logic hs, vs, bl;
        @(posedge clk);
        #1;
        cyc++;
        exp_fs = 1'b0;
        if (mphase) begin
            if (sb.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                popped = sb.pop_front();
                cur_exp = popped;
            end
            exp_fs = (mx == 0) && (my == 0);
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
        mphase = !mphase;

        check("pix", 32'(dut_pix()), 32'(cur_exp));
        check("frame_start", 32'(bus.frame_start), 32'(exp_fs));
        check("clk_en", 32'(bus.vga_clk_en), 32'(mphase));
        check("addr", 32'(bus.addressForVga), 32'(model_addr(mx, my)));
        if (mphase) sb.push_back(model_pix(mx, my));

        hs = bus.vga_hsync;
        vs = bus.vga_vsync;
        bl = bus.vga_blank_n;
        if (p_hs && !hs) begin
            if (last_hs_fall >= 0) check("line_period", cyc - last_hs_fall, LINE_CLK);
            last_hs_fall = cyc;
        end
        if (!hs) hs_lo++;
        if (!p_hs && hs) begin
            check("hsync_low", hs_lo, 2 * HS);
            hs_lo = 0;
        end
        if (!vs) vs_lo++;
        if (p_vs && !vs) begin
            check("active_lines", lines, VA);
            lines = 0;
        end
        if (!p_vs && vs) begin
            check("vsync_low", vs_lo, 2 * VS * HT);
            vs_lo = 0;
        end
        if (bl) bl_hi++;
        if (p_bl && !bl) begin
            check("blank_high", bl_hi, 2 * HA);
            bl_hi = 0;
            lines++;
        end
        if (bus.frame_start) begin
            n_fs++;
            if (last_fs >= 0) check("frame_period", cyc - last_fs, FRAME_CLK);
            last_fs = cyc;
        end
        p_hs = hs;
        p_vs = vs;
        p_bl = bl;
    endtask

    initial begin
        n_fs = 0;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_reset("reset");

        release_reset();
        repeat (FRAME_CLK + 20 * LINE_CLK + 37) step();

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset("mid_reset");
        repeat (3) @(posedge clk);

        release_reset();
        repeat (FRAME_CLK + 4 * LINE_CLK) step();

        check("frames_seen", n_fs, 4);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
